// File: rtl/fetch_queue_pkg.sv
// Shared constants and types for the fetch-to-decode instruction queue.
// Entry layout is {pc, inst}; NOP_INST is what decode sees when the queue is empty.
package fetch_queue_pkg;

  localparam int PC_W    = 64;
  localparam int INST_W  = 32;
  localparam int ENTRY_W = PC_W + INST_W;

  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fq_entry_t;

  // RVC encodings use every low-bit pattern except 2'b11.
  function automatic logic is_rvc(input logic [INST_W-1:0] inst);
    return inst[1:0] != 2'b11;
  endfunction

  function automatic bit is_pow2_ge2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Handshake bundle between fetch (master) and the queue (slave); decode-side
// signals ride in the same bundle so one instance wires the whole block.
interface fetch_queue_if
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  // Valid/ready: a transfer happens on a rising clock edge exactly when valid
  // and ready are both high; valid never waits on ready, and ready here depends
  // only on registered state.
  logic              flush_i;
  logic              enq_valid_i;
  logic [PC_W-1:0]   enq_pc_i;
  logic [INST_W-1:0] enq_inst_i;
  logic              enq_ready_o;
  logic              deq_valid_o;
  logic [PC_W-1:0]   deq_pc_o;
  logic [INST_W-1:0] deq_inst_o;
  logic              deq_ready_i;
  logic              is_compressed_o;
  logic [CW-1:0]     count_o;

  modport master (
    output flush_i, enq_valid_i, enq_pc_i, enq_inst_i, deq_ready_i,
    input  enq_ready_o, deq_valid_o, deq_pc_o, deq_inst_o, is_compressed_o, count_o
  );

  modport slave (
    input  flush_i, enq_valid_i, enq_pc_i, enq_inst_i, deq_ready_i,
    output enq_ready_o, deq_valid_o, deq_pc_o, deq_inst_o, is_compressed_o, count_o
  );

endinterface

// File: rtl/fetch_queue.sv
// Instruction queue between fetch and decode: circular buffer of {pc, inst}
// with one-cycle flush on branch redirect and RVC flag for the head entry.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic         clock,
  input logic         reset,
  fetch_queue_if.slave q
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  if (!is_pow2_ge2(DEPTH)) begin : g_bad_depth
    $error("fetch_queue: DEPTH must be a power of two and at least 2");
  end

  fq_entry_t     storage [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic enq_ready;
  logic deq_valid;
  logic enq_fire;
  logic deq_fire;

  // Ready looks only at count, so a full queue refuses even while draining.
  assign enq_ready = (count != FULL_COUNT);
  assign deq_valid = (count != '0);
  assign enq_fire  = q.enq_valid_i && enq_ready;
  assign deq_fire  = deq_valid && q.deq_ready_i;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        storage[i] <= '0;
      end
    end else if (q.flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq_fire) begin
        storage[wr_ptr] <= '{pc: q.enq_pc_i, inst: q.enq_inst_i};
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (deq_fire) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({enq_fire, deq_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  fq_entry_t head;
  assign head = storage[rd_ptr];

  always_comb begin
    q.deq_pc_o        = '0;
    q.deq_inst_o      = NOP_INST;
    q.is_compressed_o = 1'b0;
    if (deq_valid) begin
      q.deq_pc_o        = head.pc;
      q.deq_inst_o      = head.inst;
      q.is_compressed_o = is_rvc(head.inst);
    end
  end

  assign q.enq_ready_o = enq_ready;
  assign q.deq_valid_o = deq_valid;
  assign q.count_o     = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios then random traffic, all checked
// against a queue-based reference of the buffered {pc, inst} entries.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clock;
  logic reset;

  fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .q     (bus)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- scoreboard ----------------
  logic [ENTRY_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [PC_W-1:0]   e_pc;
    logic [INST_W-1:0] e_inst;
    logic              e_rvc;
    int                n;
    n      = exp_q.size();
    e_pc   = '0;
    e_inst = NOP_INST;
    e_rvc  = 1'b0;
    if (n > 0) begin
      e_pc   = exp_q[0][ENTRY_W-1:INST_W];
      e_inst = exp_q[0][INST_W-1:0];
      e_rvc  = (e_inst[1:0] != 2'b11);
    end
    check_eq({tag, ".deq_valid"}, 64'(bus.deq_valid_o), 64'(n != 0));
    check_eq({tag, ".enq_ready"}, 64'(bus.enq_ready_o), 64'(n != DEPTH));
    check_eq({tag, ".count"}, 64'(bus.count_o), 64'(n));
    check_eq({tag, ".deq_pc"}, bus.deq_pc_o, e_pc);
    check_eq({tag, ".deq_inst"}, 64'(bus.deq_inst_o), 64'(e_inst));
    check_eq({tag, ".rvc"}, 64'(bus.is_compressed_o), 64'(e_rvc));
  endtask

  // ---------------- driver ----------------
  task automatic drive_idle();
    bus.flush_i     = 1'b0;
    bus.enq_valid_i = 1'b0;
    bus.enq_pc_i    = '0;
    bus.enq_inst_i  = '0;
    bus.deq_ready_i = 1'b0;
  endtask

  // Drive one cycle, update the reference at the edge, check at the next negedge.
  task automatic step(input string tag, input logic fl, input logic ev,
                      input logic [PC_W-1:0] pc, input logic [INST_W-1:0] inst,
                      input logic dr);
    bit enq_ok;
    bit deq_ok;
    bus.flush_i     = fl;
    bus.enq_valid_i = ev;
    bus.enq_pc_i    = pc;
    bus.enq_inst_i  = inst;
    bus.deq_ready_i = dr;
    @(posedge clock);
    enq_ok = ev && (exp_q.size() < DEPTH);
    deq_ok = dr && (exp_q.size() > 0);
    if (fl) begin
      exp_q.delete();
    end else begin
      if (deq_ok) void'(exp_q.pop_front());
      if (enq_ok) exp_q.push_back({pc, inst});
    end
    @(negedge clock);
    check_outputs(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
    drive_idle();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check_outputs("in_reset");
    reset = 1'b0;

    // reset then idle
    for (int i = 0; i < 3; i++) step("idle", 0, 0, '0, '0, 0);
    check_eq("idle.inst_nop", 64'(bus.deq_inst_o), 64'h13);

    // single entry
    step("single", 0, 1, 64'h8000_0000, 32'h0050_0093, 0);
    check_eq("single.pc", bus.deq_pc_o, 64'h8000_0000);
    check_eq("single.inst", 64'(bus.deq_inst_o), 64'h0050_0093);
    check_eq("single.count", 64'(bus.count_o), 64'd1);

    // fill to full
    for (int i = 1; i < DEPTH; i++)
      step("fill", 0, 1, 64'h8000_0000 + 64'(4 * i), 32'h0000_0093 | 32'(i << 20), 0);
    check_eq("full.enq_ready", 64'(bus.enq_ready_o), 64'd0);
    check_eq("full.count", 64'(bus.count_o), 64'd4);

    // full with simultaneous deq: enqueue refused
    step("full_deq", 0, 1, 64'h9000_0000, 32'h0000_0013, 1);
    check_eq("full_deq.count", 64'(bus.count_o), 64'd3);

    // steady enq/deq through pointer wrap, count constant
    for (int i = 0; i < 8; i++) begin
      step("wrap", 0, 1, 64'hA000_0000 + 64'(4 * i), 32'h0010_0013 + 32'(i << 7), 1);
      check_eq("wrap.count", 64'(bus.count_o), 64'd3);
    end

    // drain, then RVC entry at head
    while (exp_q.size() > 0) step("drain", 0, 0, '0, '0, 1);
    step("rvc", 0, 1, 64'hB000_0002, 32'h0000_4501, 0);
    check_eq("rvc.flag", 64'(bus.is_compressed_o), 64'd1);
    step("rvc2", 0, 1, 64'hB000_0004, 32'h0000_0093, 0);
    step("rvc3", 0, 1, 64'hB000_0008, 32'h0000_0013, 0);

    // flush with count 3 plus enq and deq in the same cycle
    check_eq("pre_flush.count", 64'(bus.count_o), 64'd3);
    step("flush", 1, 1, 64'hC000_0000, 32'h0000_0093, 1);
    check_eq("flush.count", 64'(bus.count_o), 64'd0);
    check_eq("flush.deq_valid", 64'(bus.deq_valid_o), 64'd0);
    check_eq("flush.enq_ready", 64'(bus.enq_ready_o), 64'd1);

    // asynchronous reset between edges
    step("pre_ar1", 0, 1, 64'hD000_0000, 32'h0000_4501, 0);
    step("pre_ar2", 0, 1, 64'hD000_0002, 32'h0000_0093, 0);
    drive_idle();
    #2 reset = 1'b1;
    #1;
    exp_q.delete();
    check_eq("async_rst.deq_valid", 64'(bus.deq_valid_o), 64'd0);
    check_eq("async_rst.count", 64'(bus.count_o), 64'd0);
    check_eq("async_rst.inst", 64'(bus.deq_inst_o), 64'h13);
    check_eq("async_rst.rvc", 64'(bus.is_compressed_o), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    check_outputs("post_rst");

    // random traffic
    for (int i = 0; i < 400; i++) begin
      pc   = {$urandom, $urandom} & ~64'h1;
      inst = $urandom;
      if ($urandom_range(0, 2) == 0) inst[1:0] = 2'b11;
      step("rand", ($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0), pc, inst,
           ($urandom_range(0, 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
